wr_demux4: RTL and testbench

- Write-side counterpart of the datapath 4:1 select mux: routes one registered write transaction from a single source to one of four targets, selected by a 2-bit select.
- Sits between the core's memory-mapped store path and four peripheral/memory write ports.
- Holds each write until the chosen target accepts it, and aborts with an error pulse on timeout.

---
 rtl/wr_demux4_pkg.sv | 9 +
 rtl/wr_demux4_if.sv | 21 ++
 rtl/wr_demux4_dec2to4.sv | 8 +
 rtl/wr_demux4.sv | 55 +++++
 tb/tb_wr_demux4.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/wr_demux4_pkg.sv
// wr_demux4_pkg: shared state encoding, target indices and default timeout
package wr_demux4_pkg;
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
    localparam logic [1:0] TGT_A = 2'b00;
    localparam logic [1:0] TGT_B = 2'b01;
    localparam logic [1:0] TGT_C = 2'b10;
    localparam logic [1:0] TGT_D = 2'b11;
    localparam int DEF_TIMEOUT = 15;
endpackage

// File: rtl/wr_demux4_if.sv
// wr_demux4_if: source-side request and four-target write bus
interface wr_demux4_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       out_valid;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_ready;
    logic             done;
    logic             err;
    logic             busy;
    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, done, err, busy
    );
    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, done, err, busy
    );
endinterface

// File: rtl/wr_demux4_dec2to4.sv
// dec2to4: 2-to-4 one-hot decoder with enable
module dec2to4 (
    input  logic       en,
    input  logic [1:0] sel,
    output logic [3:0] y
);
    assign y = en ? 4'b0001 << sel : 4'b0000;
endmodule

// File: rtl/wr_demux4.sv
// wr_demux4: holds one write and routes it to the selected target until accepted or timed out
module wr_demux4
    import wr_demux4_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic        clk,
    input logic        rst_n,
    wr_demux4_if.slave bus
);
    state_t     state;
    logic [1:0] sel_q;
    logic [7:0] timer;

    assign bus.in_ready = state == IDLE;
    assign bus.busy     = state == HOLD;

    dec2to4 u_dec (
        .en  (state == HOLD),
        .sel (sel_q),
        .y   (bus.out_valid)
    );

    // accept in IDLE, then wait for the selected target; completion beats timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sel_q        <= 2'b00;
            timer        <= 8'd0;
            bus.out_data <= {WIDTH{1'b0}};
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            if (state == IDLE) begin
                if (bus.in_valid) begin
                    state        <= HOLD;
                    sel_q        <= bus.in_sel;
                    bus.out_data <= bus.in_data;
                    timer        <= 8'd0;
                end
            end else if (bus.out_ready[sel_q]) begin
                bus.done <= 1'b1;
                state    <= IDLE;
            end else if (timer == 8'(TIMEOUT - 1)) begin
                bus.err <= 1'b1;
                state   <= IDLE;
            end else begin
                timer <= timer + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_wr_demux4.sv
// tb_wr_demux4: randomized scoreboard bench for wr_demux4
module tb_wr_demux4;
    import wr_demux4_pkg::*;
    localparam int TO = DEF_TIMEOUT;

    typedef struct {
        bit         is_err;
        logic [1:0] sel;
        logic [31:0] data;
        int         len;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    int hold_cnt = 0;

    always #5 clk = ~clk;

    wr_demux4_if #(.WIDTH(32)) bus ();

    wr_demux4 #(.WIDTH(32), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // k = HOLD cycle index on which the selected target is ready; k >= TO means never
    task automatic txn(logic [1:0] sel, logic [31:0] data, int k, logic [3:0] noise, bit rnd);
        exp_t e;
        logic [3:0] sb;
        sb = 4'b0001 << sel;
        e.is_err = (k >= TO);
        e.sel = sel;
        e.data = data;
        e.len = e.is_err ? TO : k + 1;
        chk("in_ready_at_issue", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_sel = sel;
        bus.in_data = data;
        q.push_back(e);
        for (int i = 0; i < e.len; i++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_sel = 2'($urandom);
            bus.in_data = $urandom;
            bus.out_ready = ((rnd ? 4'($urandom) : noise) & ~sb) | (i == k ? sb : 4'b0000);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 4'b0000;
    endtask

    // monitor: check the held request every cycle and retire transactions on done/err
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid != 4'b0000) begin
                if (q.size() == 0) chk("spurious_out_valid", bus.out_valid, 0);
                else begin
                    hold_cnt++;
                    chk("out_valid", bus.out_valid, 4'b0001 << q[0].sel);
                    chk("out_data", bus.out_data, q[0].data);
                    chk("busy", bus.busy, 1);
                    chk("in_ready_hold", bus.in_ready, 0);
                end
            end
            if (bus.done || bus.err) begin
                if (q.size() == 0) chk("spurious_done_err", {bus.done, bus.err}, 0);
                else begin
                    mon_e = q.pop_front();
                    chk("done", bus.done, !mon_e.is_err);
                    chk("err", bus.err, mon_e.is_err);
                    chk("hold_len", hold_cnt, mon_e.len);
                    chk("in_ready_after", bus.in_ready, 1);
                    hold_cnt = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sel = 2'b00;
        bus.in_data = 32'h0;
        bus.out_ready = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid_rel", bus.out_valid, 0);
        chk("rst_done_err_busy", {bus.done, bus.err, bus.busy}, 0);
        chk("rst_out_data", bus.out_data, 0);
        txn(TGT_C, 32'hDEADBEEF, 0, 4'b0000, 1'b0);
        txn(TGT_B, 32'h12345678, 3, 4'b1101, 1'b0);
        txn(TGT_D, 32'hCAFEF00D, TO + 5, 4'b0000, 1'b0);
        txn(TGT_A, 32'h0BADC0DE, TO - 1, 4'b0000, 1'b1);
        txn(TGT_B, 32'hA5A5A5A5, TO, 4'b0000, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_sel = TGT_A;
        bus.in_data = 32'h55AA55AA;
        q.push_back('{1'b0, TGT_A, 32'h55AA55AA, 1});
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        hold_cnt = 0;
        #1;
        chk("async_out_valid", bus.out_valid, 0);
        chk("async_busy", bus.busy, 0);
        chk("async_in_ready", bus.in_ready, 1);
        chk("async_done_err", {bus.done, bus.err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        txn(TGT_A, 32'h600DF00D, 1, 4'b0000, 1'b1);
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            txn(2'($urandom), $urandom, int'($urandom_range(0, TO + 3)), 4'b0000, 1'b1);
        end
        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
